// File: rtl/transmit_pulse_ctrl_pkg.sv
// Shared definitions for the transmit pulse controller and its receive-side peer.
package transmit_pulse_ctrl_pkg;

  typedef enum logic [2:0] {StIdle, StGen, StLead, StMa, StTail} tx_state_e;

  localparam logic [15:0] OFFS_PERIOD   = 16'd0;
  localparam logic [15:0] OFFS_LEAD     = 16'd1;
  localparam logic [15:0] OFFS_MA_W     = 16'd2;
  localparam logic [15:0] OFFS_TAIL     = 16'd3;
  localparam logic [15:0] OFFS_TRIG_SRC = 16'd4;

  localparam logic SW_ON  = 1'b0;
  localparam logic SW_OFF = 1'b1;

  // Edge codes as {previous, current} of a synchronized level
  localparam logic [1:0] RAISE = 2'b01;
  localparam logic [1:0] FALL  = 2'b10;

  localparam logic [7:0] MODE_TX_SINGLE = 8'd1;
  localparam logic [7:0] MODE_TX_DUAL   = 8'd3;

  localparam logic [15:0] LEAD_DEFAULT = 16'd10;
  localparam logic [15:0] MA_W_DEFAULT = 16'd20;
  localparam logic [15:0] TAIL_DEFAULT = 16'd30;

  function automatic logic is_tx_mode(input logic [7:0] mode);
    return (mode == MODE_TX_SINGLE) || (mode == MODE_TX_DUAL);
  endfunction

  function automatic logic [15:0] at_least_one(input logic [15:0] val);
    return (val == 16'd0) ? 16'd1 : val;
  endfunction

endpackage

// File: rtl/transmit_pulse_ctrl_edge_sync.sv
// Two-flop synchronizer with a single-cycle pulse on each rising edge of the input.
module edge_sync
  import transmit_pulse_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = ({prev_q, sync_q} == RAISE);

endmodule

// File: rtl/transmit_pulse_ctrl.sv
// Per-shot PRE_GEN / RF_MA / transmit-switch sequencer with host-programmable timing.
module transmit_pulse_ctrl
  import transmit_pulse_ctrl_pkg::*;
#(
  parameter logic        ON        = SW_ON,
  parameter logic        OFF       = SW_OFF,
  parameter int unsigned GEN_WIDTH = 2,
  parameter int unsigned ADDR_BASE = 161
) (
  input  logic        CLOCK_10M,
  input  logic        RST,
  input  logic        TR,
  input  logic [15:0] ADDR,
  input  logic [31:0] DATA,
  input  logic        TX_EN,
  input  logic [7:0]  PROBE_MODE,
  input  logic        EXT_TRIG,
  output logic        PRE_GEN,
  output logic        RF_MA,
  output logic        TRANSMIT_SW,
  output logic        BUSY
);

  localparam logic [15:0] GEN_LOAD = 16'(GEN_WIDTH - 1);

  logic        tr_rise, ext_rise;
  logic [15:0] period_q, lead_q, ma_w_q, tail_q;
  logic        trig_src_q;
  logic [15:0] reg_offs;
  logic        unused_data;
  logic        shot_en, int_fire, trig;
  logic [15:0] per_cnt_q;

  tx_state_e   state_q;
  logic [15:0] cnt_q, lead_sh_q, ma_sh_q, tail_sh_q;
  logic        pre_gen_q, rf_ma_q, sw_q, busy_q;

  edge_sync u_tr_sync (
    .clk_i  (CLOCK_10M),
    .rst_i  (RST),
    .d_i    (TR),
    .rise_o (tr_rise)
  );

  edge_sync u_trig_sync (
    .clk_i  (CLOCK_10M),
    .rst_i  (RST),
    .d_i    (EXT_TRIG),
    .rise_o (ext_rise)
  );

  assign reg_offs    = ADDR - 16'(ADDR_BASE);
  assign unused_data = ^DATA[31:16];

  // ADDR/DATA are held while TR is high, so they are stable when the synced edge arrives
  always_ff @(posedge CLOCK_10M or posedge RST) begin
    if (RST) begin
      period_q   <= 16'd0;
      lead_q     <= LEAD_DEFAULT;
      ma_w_q     <= MA_W_DEFAULT;
      tail_q     <= TAIL_DEFAULT;
      trig_src_q <= 1'b0;
    end else if (tr_rise) begin
      case (reg_offs)
        OFFS_PERIOD:   period_q   <= DATA[15:0];
        OFFS_LEAD:     lead_q     <= DATA[15:0];
        OFFS_MA_W:     ma_w_q     <= DATA[15:0];
        OFFS_TAIL:     tail_q     <= DATA[15:0];
        OFFS_TRIG_SRC: trig_src_q <= DATA[0];
        default: ;
      endcase
    end
  end

  assign shot_en  = TX_EN && is_tx_mode(PROBE_MODE);
  assign int_fire = shot_en && (period_q != 16'd0) && (per_cnt_q >= period_q);
  assign trig     = trig_src_q ? int_fire : ext_rise;

  // >= rather than == so a PERIOD shrunk below the running count still wraps promptly
  always_ff @(posedge CLOCK_10M or posedge RST) begin
    if (RST) begin
      per_cnt_q <= 16'd0;
    end else if (!shot_en || (period_q == 16'd0) || (per_cnt_q >= period_q)) begin
      per_cnt_q <= 16'd0;
    end else begin
      per_cnt_q <= per_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_10M or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      lead_sh_q <= 16'd0;
      ma_sh_q   <= 16'd0;
      tail_sh_q <= 16'd0;
      pre_gen_q <= 1'b0;
      rf_ma_q   <= 1'b0;
      sw_q      <= OFF;
      busy_q    <= 1'b0;
    end else if (!shot_en) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      pre_gen_q <= 1'b0;
      rf_ma_q   <= 1'b0;
      sw_q      <= OFF;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            state_q   <= StGen;
            cnt_q     <= GEN_LOAD;
            lead_sh_q <= lead_q;
            ma_sh_q   <= ma_w_q;
            tail_sh_q <= tail_q;
            pre_gen_q <= 1'b1;
            sw_q      <= ON;
            busy_q    <= 1'b1;
          end
        end
        StGen: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q   <= StLead;
            cnt_q     <= at_least_one(lead_sh_q) - 16'd1;
            pre_gen_q <= 1'b0;
          end
        end
        StLead: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (ma_sh_q != 16'd0) begin
            state_q <= StMa;
            cnt_q   <= ma_sh_q - 16'd1;
            rf_ma_q <= 1'b1;
          end else if (tail_sh_q != 16'd0) begin
            state_q <= StTail;
            cnt_q   <= tail_sh_q - 16'd1;
          end else begin
            state_q <= StIdle;
            sw_q    <= OFF;
            busy_q  <= 1'b0;
          end
        end
        StMa: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            rf_ma_q <= 1'b0;
            if (tail_sh_q != 16'd0) begin
              state_q <= StTail;
              cnt_q   <= tail_sh_q - 16'd1;
            end else begin
              state_q <= StIdle;
              sw_q    <= OFF;
              busy_q  <= 1'b0;
            end
          end
        end
        StTail: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else begin
            state_q <= StIdle;
            sw_q    <= OFF;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PRE_GEN     = pre_gen_q;
  assign RF_MA       = rf_ma_q;
  assign TRANSMIT_SW = sw_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_transmit_pulse_ctrl.sv
// Directed bench for transmit_pulse_ctrl: shot timing, trigger sources, shadowing, abort, reset.
module tb_transmit_pulse_ctrl;

  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        tr;
  logic [15:0] addr;
  logic [31:0] data;
  logic        tx_en;
  logic [7:0]  probe_mode;
  logic        ext_trig;
  logic        pre_gen, rf_ma, transmit_sw, busy;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, updated on the falling edge
  int cyc = 0;
  int pg_run = 0, last_pg_len = 0, pg_rise_cyc = 0, pg_count = 0;
  int ma_run = 0, last_ma_len = 0, ma_rise_cyc = 0, ma_pulses = 0;
  int sw_run = 0, last_sw_len = 0, sw_pulses = 0;
  int busy_bad = 0;

  transmit_pulse_ctrl dut (
    .CLOCK_10M   (clk),
    .RST         (rst),
    .TR          (tr),
    .ADDR        (addr),
    .DATA        (data),
    .TX_EN       (tx_en),
    .PROBE_MODE  (probe_mode),
    .EXT_TRIG    (ext_trig),
    .PRE_GEN     (pre_gen),
    .RF_MA       (rf_ma),
    .TRANSMIT_SW (transmit_sw),
    .BUSY        (busy)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pre_gen === 1'b1) begin
      if (pg_run == 0) begin
        pg_rise_cyc <= cyc;
        pg_count    <= pg_count + 1;
      end
      pg_run <= pg_run + 1;
    end else if (pg_run != 0) begin
      last_pg_len <= pg_run;
      pg_run      <= 0;
    end
    if (rf_ma === 1'b1) begin
      if (ma_run == 0) ma_rise_cyc <= cyc;
      ma_run <= ma_run + 1;
    end else if (ma_run != 0) begin
      last_ma_len <= ma_run;
      ma_run      <= 0;
      ma_pulses   <= ma_pulses + 1;
    end
    if (transmit_sw === ON) begin
      sw_run <= sw_run + 1;
    end else if (sw_run != 0) begin
      last_sw_len <= sw_run;
      sw_run      <= 0;
      sw_pulses   <= sw_pulses + 1;
    end
    if (busy !== (transmit_sw === ON)) busy_bad <= busy_bad + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input int unsigned offs, input logic [15:0] val);
    addr = 16'(32'd161 + offs);
    data = {16'hA5A5, val};
    tr   = 1'b1;
    tick(4);
    tr   = 1'b0;
    tick(4);
  endtask

  task automatic fire_ext();
    ext_trig = 1'b1;
    tick(3);
    ext_trig = 1'b0;
  endtask

  task automatic wait_shots(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick(1);
      if (sw_pulses >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_rf_ma(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      if (rf_ma === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (pre_gen !== 1'b0) begin errors++; $display("FAIL reset_pre_gen got %b want 0", pre_gen); end
    checks++; if (rf_ma !== 1'b0) begin errors++; $display("FAIL reset_rf_ma got %b want 0", rf_ma); end
    checks++; if (transmit_sw !== OFF) begin errors++; $display("FAIL reset_sw got %b want %b", transmit_sw, OFF); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick(10);
    checks++; if (transmit_sw !== OFF) begin errors++; $display("FAIL idle_no_trig_sw got %b want %b", transmit_sw, OFF); end
  endtask

  task automatic test_ext_shot();
    int base = sw_pulses;
    bit ok;
    fire_ext();
    wait_shots(base + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ext_shot_done got timeout want shot end"); end
    checks++; if (last_pg_len !== 2) begin errors++; $display("FAIL ext_pg_len got %0d want 2", last_pg_len); end
    checks++; if (ma_rise_cyc - pg_rise_cyc !== 12) begin errors++; $display("FAIL ext_ma_delay got %0d want 12", ma_rise_cyc - pg_rise_cyc); end
    checks++; if (last_ma_len !== 20) begin errors++; $display("FAIL ext_ma_len got %0d want 20", last_ma_len); end
    checks++; if (last_sw_len !== 62) begin errors++; $display("FAIL ext_sw_len got %0d want 62", last_sw_len); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_mirror got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_internal();
    int base, nr, ext_at;
    int rises[3];
    bit pulsed;
    tx_en = 1'b0;
    reg_write(0, 16'd999);
    reg_write(4, 16'd1);
    base   = pg_count;
    nr     = 0;
    pulsed = 1'b0;
    ext_at = 0;
    rises  = '{0, 0, 0};
    tx_en  = 1'b1;
    for (int i = 0; i < 3500 && nr < 3; i++) begin
      tick(1);
      if (pg_count - base > nr) begin
        rises[nr] = pg_rise_cyc;
        nr++;
      end
      if (nr == 1 && !pulsed && cyc >= rises[0] + 300) begin
        ext_trig = 1'b1;
        pulsed   = 1'b1;
        ext_at   = cyc;
      end
      if (pulsed && ext_trig && cyc >= ext_at + 10) ext_trig = 1'b0;
    end
    ext_trig = 1'b0;
    checks++; if (nr !== 3) begin errors++; $display("FAIL int_shot_count got %0d want 3", nr); end
    checks++; if (rises[1] - rises[0] !== 1000) begin errors++; $display("FAIL int_interval1 got %0d want 1000", rises[1] - rises[0]); end
    checks++; if (rises[2] - rises[1] !== 1000) begin errors++; $display("FAIL int_interval2 got %0d want 1000", rises[2] - rises[1]); end
    tx_en = 1'b0;
    reg_write(4, 16'd0);
    reg_write(0, 16'd0);
    tx_en = 1'b1;
    tick(4);
  endtask

  task automatic test_shadow_write();
    int base = sw_pulses;
    bit ok;
    ext_trig = 1'b1;
    wait_rf_ma(ok);
    checks++; if (!ok) begin errors++; $display("FAIL shadow_ma_start got timeout want rf_ma high"); end
    reg_write(2, 16'd50);
    ext_trig = 1'b0;
    wait_shots(base + 1, ok);
    checks++; if (last_ma_len !== 20) begin errors++; $display("FAIL shadow_cur_ma got %0d want 20", last_ma_len); end
    checks++; if (last_sw_len !== 62) begin errors++; $display("FAIL shadow_cur_sw got %0d want 62", last_sw_len); end
    fire_ext();
    wait_shots(base + 2, ok);
    checks++; if (last_ma_len !== 50) begin errors++; $display("FAIL shadow_next_ma got %0d want 50", last_ma_len); end
    checks++; if (last_sw_len !== 92) begin errors++; $display("FAIL shadow_next_sw got %0d want 92", last_sw_len); end
  endtask

  task automatic test_abort();
    int sw_after;
    bit ok;
    ext_trig = 1'b1;
    wait_rf_ma(ok);
    tick(5);
    probe_mode = 8'd4;
    tick(1);
    checks++; if (rf_ma !== 1'b0) begin errors++; $display("FAIL abort_rf_ma got %b want 0", rf_ma); end
    checks++; if (transmit_sw !== OFF) begin errors++; $display("FAIL abort_sw got %b want %b", transmit_sw, OFF); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    ext_trig = 1'b0;
    tick(2);
    probe_mode = 8'd1;
    sw_after   = sw_pulses;
    tick(200);
    checks++; if (sw_pulses !== sw_after) begin errors++; $display("FAIL abort_no_resume got %0d shots want %0d", sw_pulses, sw_after); end
    checks++; if (transmit_sw !== OFF) begin errors++; $display("FAIL abort_idle_sw got %b want %b", transmit_sw, OFF); end
  endtask

  task automatic test_zero_widths();
    int base, base_ma;
    bit ok;
    probe_mode = 8'd3;
    reg_write(2, 16'd0);
    reg_write(1, 16'd0);
    base    = sw_pulses;
    base_ma = ma_pulses;
    fire_ext();
    wait_shots(base + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_shot_done got timeout want shot end"); end
    checks++; if (last_sw_len !== 33) begin errors++; $display("FAIL zero_sw_len got %0d want 33", last_sw_len); end
    checks++; if (ma_pulses !== base_ma) begin errors++; $display("FAIL zero_no_ma got %0d pulses want %0d", ma_pulses, base_ma); end
    checks++; if (last_pg_len !== 2) begin errors++; $display("FAIL zero_pg_len got %0d want 2", last_pg_len); end
  endtask

  task automatic test_async_reset();
    int base;
    bit ok;
    probe_mode = 8'd1;
    fire_ext();
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick(1);
      if (transmit_sw === ON) ok = 1'b1;
    end
    tick(5);
    #20 rst = 1'b1;
    #1;
    checks++; if (transmit_sw !== OFF) begin errors++; $display("FAIL arst_sw got %b want %b", transmit_sw, OFF); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    checks++; if (pre_gen !== 1'b0 || rf_ma !== 1'b0) begin errors++; $display("FAIL arst_pulses got %b%b want 00", pre_gen, rf_ma); end
    #10 rst = 1'b0;
    tick(3);
    base = sw_pulses;
    fire_ext();
    wait_shots(base + 1, ok);
    checks++; if (last_sw_len !== 62) begin errors++; $display("FAIL arst_defaults_sw got %0d want 62", last_sw_len); end
    checks++; if (last_ma_len !== 20) begin errors++; $display("FAIL arst_defaults_ma got %0d want 20", last_ma_len); end
  endtask

  initial begin
    rst        = 1'b1;
    tr         = 1'b0;
    addr       = 16'd0;
    data       = 32'd0;
    tx_en      = 1'b1;
    probe_mode = 8'd1;
    ext_trig   = 1'b0;
    test_reset();
    test_ext_shot();
    test_internal();
    test_shadow_write();
    test_abort();
    test_zero_widths();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
